// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_responder_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] ERR_DATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A fetch address is bad when it is not word aligned or its word index
    // falls past the end of the array.
    function automatic logic addr_is_bad(input logic [31:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= $unsigned(depth));
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage with one synchronous write and one async read.
// Latency: write lands at the clock edge; read is combinational.
// Backpressure: none; the array accepts a write every cycle.
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset so boot-loaded code survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read is combinational; the caller registers it on the same edge as any
    // write, which gives read-before-write on a same-index collision.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: accepts one request at a time, returns the word after WAIT_CYCLES.
// Latency: accept at edge T -> rsp_valid in the cycle after edge T+WAIT_CYCLES.
// Backpressure: rsp held stable while rsp_ready=0; req_ready follows rsp_ready in RESP.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data,
    output logic [CNT_W-1:0]         rsp_count
);

    localparam int AW = $clog2(DEPTH);
    // With no wait states an accepted request goes straight to the response.
    localparam state_t ST_AFTER_ACCEPT = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;

    state_t             state, state_nxt;
    logic [3:0]         wait_cnt, wait_cnt_nxt;
    logic               accept;
    logic               rsp_fire;
    logic               bad_addr;
    logic [INSTR_W-1:0] rd_data;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (ld_en && reset),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_addr (req_addr[AW+1:2]),
        .rd_data (rd_data)
    );

    assign accept   = req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;
    assign bad_addr = addr_is_bad(req_addr, DEPTH);

    // Next-state, wait countdown and handshake outputs.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt    = ST_AFTER_ACCEPT;
                    wait_cnt_nxt = 4'(WAIT_CYCLES);
                end
            end
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                // A new request may only enter as the current response leaves.
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    if (req_valid) begin
                        state_nxt    = ST_AFTER_ACCEPT;
                        wait_cnt_nxt = 4'(WAIT_CYCLES);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and wait counter; reset drops any pending request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Response word is captured at the accept edge so later loads cannot disturb it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            rsp_err  <= bad_addr;
            rsp_data <= bad_addr ? ERR_DATA : rd_data;
        end
    end

    // Completed-handshake counter, free-running wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_count <= '0;
        end else if (rsp_fire) begin
            rsp_count <= rsp_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (0 and 1 wait states) against a transaction model.
// Latency: model predicts cycle-exact valid/ready from accept time plus wait states.
// Backpressure: randomised rsp_ready; requests held until accepted.
module tb_imem_responder;

    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [31:0]       req_addr [2];
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [31:0]       rsp_data [2];
    logic [1:0]        rsp_err;
    logic [1:0]        ld_en;
    logic [5:0]        ld_addr [2];
    logic [31:0]       ld_data [2];
    logic [15:0]       rsp_count [2];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    // Reference model state, one slot per instance.
    bit [31:0] m_mem  [2][DEPTH];
    bit        m_pend [2];
    int        m_left [2];
    bit [31:0] m_data [2];
    bit        m_err  [2];
    bit [15:0] m_cnt  [2];
    bit        m_acc  [2];

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_err(rsp_err[0]), .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]),
        .rsp_count(rsp_count[0])
    );

    imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_err(rsp_err[1]), .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]),
        .rsp_count(rsp_count[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int wait_of(input int g);
        return (g == 0) ? 0 : 1;
    endfunction

    function automatic bit f_valid(input int g);
        return m_pend[g] && (m_left[g] == 0);
    endfunction

    function automatic bit f_ready(input int g);
        return !m_pend[g] || (f_valid(g) && rsp_ready[g]);
    endfunction

    function automatic bit [31:0] preload_word(input int g, input int i);
        return 32'hA000_0000 | (32'(g) << 16) | 32'(i);
    endfunction

    // Transaction model: a pending fetch becomes visible wait_of(g) edges after acceptance.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            m_acc[g] <= 1'b0;
            if (!reset) begin
                m_pend[g] <= 1'b0;
                m_left[g] <= 0;
                m_cnt[g]  <= '0;
                m_data[g] <= '0;
                m_err[g]  <= 1'b0;
            end else begin
                if (f_valid(g) && rsp_ready[g]) begin
                    m_cnt[g]  <= m_cnt[g] + 16'd1;
                    m_pend[g] <= 1'b0;
                end else if (m_pend[g] && m_left[g] > 0) begin
                    m_left[g] <= m_left[g] - 1;
                end
                if (req_valid[g] && f_ready(g)) begin
                    m_acc[g]  <= 1'b1;
                    m_pend[g] <= 1'b1;
                    m_left[g] <= wait_of(g);
                    if (req_addr[g][1:0] != 2'b00 || (req_addr[g] >> 2) >= 32'(DEPTH)) begin
                        m_err[g]  <= 1'b1;
                        m_data[g] <= 32'h0;
                    end else begin
                        m_err[g]  <= 1'b0;
                        m_data[g] <= m_mem[g][req_addr[g][7:2]];
                    end
                end
                if (ld_en[g]) begin
                    m_mem[g][ld_addr[g]] <= ld_data[g];
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("rsp_valid%0d", g), 32'(rsp_valid[g]), 32'(f_valid(g)));
                chk($sformatf("req_ready%0d", g), 32'(req_ready[g]), 32'(f_ready(g)));
                chk($sformatf("rsp_count%0d", g), 32'(rsp_count[g]), 32'(m_cnt[g]));
                if (f_valid(g)) begin
                    chk($sformatf("rsp_data%0d", g), rsp_data[g], m_data[g]);
                    chk($sformatf("rsp_err%0d", g), 32'(rsp_err[g]), 32'(m_err[g]));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One fetch on the one-wait-state instance, starting from idle.
    task automatic fetch1(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e);
        req_valid[1] = 1'b1;
        req_addr[1]  = addr;
        rsp_ready[1] = 1'b1;
        step(1);
        req_valid[1] = 1'b0;
        chk("fetch1_wait", 32'(rsp_valid[1]), 32'd0);
        step(1);
        chk("fetch1_valid", 32'(rsp_valid[1]), 32'd1);
        chk("fetch1_data", rsp_data[1], exp_d);
        chk("fetch1_err", 32'(rsp_err[1]), 32'(exp_e));
        step(1);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
        if (r == 8) return {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        return $urandom | 32'h0000_0100;
    endfunction

    initial begin
        reset     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        ld_en     = 2'b00;
        for (int g = 0; g < 2; g++) begin
            req_addr[g] = 32'h0;
            ld_addr[g]  = '0;
            ld_data[g]  = '0;
        end

        // Reset held with a request present: nothing may be accepted.
        step(1);
        chk_on = 1'b1;
        step(1);
        chk("rst_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rst_count", 32'(rsp_count[1]), 32'd0);
        chk("rst_data", rsp_data[1], 32'h0);
        req_valid = 2'b00;
        reset     = 1'b1;
        step(1);
        chk("idle_ready", 32'(req_ready[1]), 32'd1);
        chk("idle_valid", 32'(rsp_valid[1]), 32'd0);

        // Fill both arrays with known words.
        for (int i = 0; i < DEPTH; i++) begin
            ld_en = 2'b11;
            for (int g = 0; g < 2; g++) begin
                ld_addr[g] = 6'(i);
                ld_data[g] = preload_word(g, i);
            end
            step(1);
        end
        ld_en = 2'b00;

        // Load then fetch with one wait state.
        ld_en[1]   = 1'b1;
        ld_addr[1] = 6'd3;
        ld_data[1] = 32'hDEAD_BEEF;
        step(1);
        ld_en[1] = 1'b0;
        fetch1(32'h0000_000C, 32'hDEAD_BEEF, 1'b0);
        chk("count_after_1", 32'(rsp_count[1]), 32'd1);

        // Backpressure with a same-index load during the stall.
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h0000_000C;
        step(1);
        req_valid[1] = 1'b0;
        step(1);
        for (int k = 0; k < 5; k++) begin
            ld_en[1]   = (k == 0);
            ld_addr[1] = 6'd3;
            ld_data[1] = 32'h1234_5678;
            chk("stall_valid", 32'(rsp_valid[1]), 32'd1);
            chk("stall_data", rsp_data[1], 32'hDEAD_BEEF);
            chk("stall_ready", 32'(req_ready[1]), 32'd0);
            step(1);
        end
        ld_en[1]     = 1'b0;
        rsp_ready[1] = 1'b1;
        step(1);
        chk("count_after_stall", 32'(rsp_count[1]), 32'd2);

        // Misaligned and out-of-range fetches.
        fetch1(32'h0000_0002, 32'h0, 1'b1);
        fetch1(32'h0000_0100, 32'h0, 1'b1);
        chk("count_after_err", 32'(rsp_count[1]), 32'd4);
        fetch1(32'h0000_000C, 32'h1234_5678, 1'b0);

        // Back-to-back on the zero-wait instance, same-edge load to index 1.
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid[0] = 1'b1;
            req_addr[0]  = 32'(4 * i);
            ld_en[0]     = (i == 1);
            ld_addr[0]   = 6'd1;
            ld_data[0]   = 32'hCAFE_0001;
            step(1);
            chk("b2b_valid", 32'(rsp_valid[0]), 32'd1);
            chk("b2b_data", rsp_data[0], preload_word(0, i));
        end
        req_valid[0] = 1'b0;
        ld_en[0]     = 1'b0;
        step(1);
        chk("b2b_count", 32'(rsp_count[0]), 32'd4);
        chk("b2b_idle", 32'(rsp_valid[0]), 32'd0);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_0004;
        step(1);
        req_valid[0] = 1'b0;
        chk("b2b_newword", rsp_data[0], 32'hCAFE_0001);
        step(1);

        // Reset while a fetch is waiting: its response must never appear.
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h0000_000C;
        step(1);
        req_valid[1] = 1'b0;
        reset        = 1'b0;
        step(1);
        reset = 1'b1;
        chk("rstw_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rstw_ready", 32'(req_ready[1]), 32'd1);
        step(2);
        chk("rstw_quiet", 32'(rsp_valid[1]), 32'd0);
        fetch1(32'h0000_000C, 32'h1234_5678, 1'b0);
        chk("rstw_count", 32'(rsp_count[1]), 32'd1);

        // Randomised traffic on both instances.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 399) != 0);
            for (int g = 0; g < 2; g++) begin
                if (!(req_valid[g] && !m_acc[g])) begin
                    req_valid[g] = ($urandom_range(0, 9) < 6);
                    req_addr[g]  = rand_addr();
                end
                rsp_ready[g] = ($urandom_range(0, 9) < 7);
                ld_en[g]     = ($urandom_range(0, 3) == 0);
                ld_addr[g]   = 6'($urandom_range(0, DEPTH - 1));
                ld_data[g]   = $urandom;
            end
            step(1);
        end
        reset     = 1'b1;
        req_valid = 2'b00;
        ld_en     = 2'b00;
        rsp_ready = 2'b11;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
